prog_clk_divider: RTL and testbench

- Runtime-programmable integer clock divider producing a 50%-duty `clk_out` for any ratio N from 2 to 2^DIV_W-1, odd or even.
- Generalises the fixed divide-by-5 block:
  - ratio is loadable at runtime;
  - supports enable/stop;
  - emits a period-start strobe;
  - ratio changes are glitch-free.
- Sits in the clock-generation area, feeding slow-domain logic from the system clock.

---
 rtl/prog_clk_divider.sv | 130 +++++++++++++
 tb/tb_prog_clk_divider.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider with a 50%-duty clk_out for any ratio 2..2^DIV_W-1.
// Latency: clk_out rises and tick pulses at the first posedge that samples en=1 in IDLE.
// No backpressure: ratio loads are accepted every cycle and queued until the next period boundary.
module prog_clk_divider #(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] div_cur,
  output logic             err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] pend, pend_nxt, pend_eff;
  logic             pend_vld, pend_vld_nxt, pend_eff_vld;
  logic             load_ok, load_bad;
  logic             apply;
  logic             tick_nxt;
  logic             err_nxt;
  logic             hi_p, hi_p_nxt;
  logic             hi_n;

  // A ratio below 2 cannot produce a clock; such loads only flag err.
  assign load_ok  = div_load && (div_in >= TWO);
  assign load_bad = div_load && (div_in < TWO);

  // Next-state, counter, ratio hand-over and high-phase decode.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    tick_nxt     = 1'b0;
    apply        = 1'b0;
    // A load arriving on the boundary cycle takes effect at that same boundary.
    pend_eff     = load_ok ? div_in : pend;
    pend_eff_vld = load_ok | pend_vld;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en) begin
          apply     = 1'b1;
          state_nxt = RUN;
          tick_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (cnt != div_cur - ONE) begin
          cnt_nxt = cnt + ONE;
        end else begin
          // Period end: the only point where the ratio may change.
          apply   = 1'b1;
          cnt_nxt = '0;
          if (en) begin
            tick_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    div_nxt      = (apply && pend_eff_vld) ? pend_eff : div_cur;
    pend_nxt     = pend_eff;
    pend_vld_nxt = apply ? 1'b0 : pend_eff_vld;

    err_nxt = err;
    if (load_bad) begin
      err_nxt = 1'b1;
    end else if (load_ok) begin
      err_nxt = 1'b0;
    end

    // High for the first floor(N/2) cycles of each period.
    hi_p_nxt = (state_nxt == RUN) && (cnt_nxt < (div_nxt >> 1));
  end

  // Rising-edge state: FSM, counter, ratio, pending load, strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_p     <= 1'b0;
      tick     <= 1'b0;
      err      <= 1'b0;
      div_cur  <= DIV_RST;
      pend     <= '0;
      pend_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hi_p     <= hi_p_nxt;
      tick     <= tick_nxt;
      err      <= err_nxt;
      div_cur  <= div_nxt;
      pend     <= pend_nxt;
      pend_vld <= pend_vld_nxt;
    end
  end

  // Half-cycle delayed copy of hi_p, stretches the high phase for odd ratios.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_n <= 1'b0;
    end else begin
      hi_n <= hi_p;
    end
  end

  // hi_n is always low at a period boundary, so the select change at the wrap cannot glitch.
  assign clk_out = div_cur[0] ? (hi_p | hi_n) : hi_p;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider: reset, default ratio, mid-period load, ratio sweep, err, stop, async reset.
// Latency: tests step on posedge+1 and negedge+1; clk_out is sampled every half clk period.
// No backpressure: inputs are driven right after a sampling point and held for whole cycles.
module tb_prog_clk_divider;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       div_load;
  logic [7:0] div_in;
  logic       clk_out;
  logic       tick;
  logic [7:0] div_cur;
  logic       err;

  int total;
  int passed;

  prog_clk_divider #(.DIV_W(8), .DIV_RESET(5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .div_load (div_load),
    .div_in   (div_in),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_cur  (div_cur),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] val);
    div_in   = val;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Measures one full clk_out period in half clk periods; returns at the next rising edge.
  task automatic measure(output int hi, output int lo, output bit ok);
    int n;
    ok = 1'b0;
    hi = 0;
    lo = 0;
    n  = 0;
    while (clk_out !== 1'b0 && n < 2000) begin @(clk); #1; n++; end
    while (clk_out !== 1'b1 && n < 2000) begin @(clk); #1; n++; end
    while (clk_out === 1'b1 && n < 2000) begin hi++; @(clk); #1; n++; end
    while (clk_out === 1'b0 && n < 2000) begin lo++; @(clk); #1; n++; end
    ok = (n < 2000);
  endtask

  task automatic test_reset();
    #12;
    total++; if (clk_out !== 1'b0) $display("FAIL reset_clk_out: got %b want 0", clk_out); else passed++;
    total++; if (tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", tick); else passed++;
    total++; if (div_cur !== 8'd5) $display("FAIL reset_div_cur: got %0d want 5", div_cur); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    total++; if (clk_out !== 1'b0) $display("FAIL idle_clk_out: got %b want 0", clk_out); else passed++;
  endtask

  task automatic test_default();
    int hi, lo, ticks;
    bit ok;
    en = 1'b1;
    step();
    total++; if (clk_out !== 1'b1) $display("FAIL default_first_rise: got %b want 1", clk_out); else passed++;
    total++; if (tick !== 1'b1) $display("FAIL default_first_tick: got %b want 1", tick); else passed++;
    step();
    total++; if (tick !== 1'b0) $display("FAIL default_tick_one_cycle: got %b want 0", tick); else passed++;
    total++; if (clk_out !== 1'b1) $display("FAIL default_cnt1_high: got %b want 1", clk_out); else passed++;
    ticks = 0;
    repeat (20) begin
      step();
      if (tick === 1'b1) ticks++;
    end
    total++; if (ticks !== 4) $display("FAIL default_tick_rate: got %0d ticks want 4 in 20 cycles", ticks); else passed++;
    measure(hi, lo, ok);
    total++; if (!ok || hi !== 5 || lo !== 5)
      $display("FAIL default_shape: got hi=%0d lo=%0d ok=%0d want hi=5 lo=5 halves", hi, lo, ok); else passed++;
  endtask

  task automatic test_load_mid();
    int hi, lo;
    bit ok;
    wait_tick(ok);
    total++; if (!ok) $display("FAIL loadmid_wait_tick: got timeout want tick"); else passed++;
    step();
    load(8'd4);
    total++; if (div_cur !== 8'd5) $display("FAIL loadmid_cnt2_div: got %0d want 5", div_cur); else passed++;
    step();
    step();
    total++; if (div_cur !== 8'd5 || clk_out !== 1'b0 || tick !== 1'b0)
      $display("FAIL loadmid_cnt4: got div=%0d clk=%b tick=%b want 5/0/0", div_cur, clk_out, tick); else passed++;
    step();
    total++; if (div_cur !== 8'd4 || tick !== 1'b1 || clk_out !== 1'b1)
      $display("FAIL loadmid_wrap: got div=%0d tick=%b clk=%b want 4/1/1", div_cur, tick, clk_out); else passed++;
    measure(hi, lo, ok);
    total++; if (!ok || hi !== 4 || lo !== 4)
      $display("FAIL loadmid_shape: got hi=%0d lo=%0d ok=%0d want hi=4 lo=4 halves", hi, lo, ok); else passed++;
  endtask

  task automatic test_err();
    int hi, lo;
    bit ok;
    load(8'd1);
    total++; if (err !== 1'b1 || div_cur !== 8'd4)
      $display("FAIL err_load1: got err=%b div=%0d want 1/4", err, div_cur); else passed++;
    load(8'd0);
    total++; if (err !== 1'b1 || div_cur !== 8'd4)
      $display("FAIL err_load0: got err=%b div=%0d want 1/4", err, div_cur); else passed++;
    load(8'd6);
    total++; if (err !== 1'b0) $display("FAIL err_clear: got %b want 0", err); else passed++;
    wait_tick(ok);
    total++; if (!ok || div_cur !== 8'd6)
      $display("FAIL err_new_ratio: got div=%0d ok=%0d want 6", div_cur, ok); else passed++;
    measure(hi, lo, ok);
    total++; if (!ok || hi !== 6 || lo !== 6)
      $display("FAIL err_shape: got hi=%0d lo=%0d ok=%0d want hi=6 lo=6 halves", hi, lo, ok); else passed++;
  endtask

  task automatic test_ratios();
    int ratios[4]   = '{2, 3, 255, 7};
    int exp_half[4] = '{2, 3, 255, 7};
    int prev;
    int hi, lo;
    bit ok;
    prev = 6;
    for (int k = 0; k < 4; k++) begin
      en = 1'b0;
      repeat (prev + 2) step();
      total++; if (clk_out !== 1'b0 || tick !== 1'b0)
        $display("FAIL ratio%0d_idle: got clk=%b tick=%b want 0/0", ratios[k], clk_out, tick); else passed++;
      load(8'(ratios[k]));
      total++; if (div_cur !== 8'(prev))
        $display("FAIL ratio%0d_held: got div=%0d want %0d", ratios[k], div_cur, prev); else passed++;
      en = 1'b1;
      step();
      total++; if (div_cur !== 8'(ratios[k]) || tick !== 1'b1 || clk_out !== 1'b1)
        $display("FAIL ratio%0d_start: got div=%0d tick=%b clk=%b want %0d/1/1", ratios[k], div_cur, tick, clk_out, ratios[k]); else passed++;
      measure(hi, lo, ok);
      total++; if (!ok || hi !== exp_half[k] || lo !== exp_half[k])
        $display("FAIL ratio%0d_shape: got hi=%0d lo=%0d ok=%0d want %0d halves each", ratios[k], hi, lo, ok, exp_half[k]); else passed++;
      prev = ratios[k];
    end
  endtask

  task automatic test_stop();
    int highs;
    bit ok;
    wait_tick(ok);
    total++; if (!ok || div_cur !== 8'd7)
      $display("FAIL stop_wait_tick: got div=%0d ok=%0d want 7", div_cur, ok); else passed++;
    step();
    en = 1'b0;
    step();
    total++; if (clk_out !== 1'b1) $display("FAIL stop_cnt2_high: got %b want 1", clk_out); else passed++;
    step();
    total++; if (clk_out !== 1'b1) $display("FAIL stop_cnt3_half_high: got %b want 1", clk_out); else passed++;
    @(negedge clk);
    #1;
    total++; if (clk_out !== 1'b0) $display("FAIL stop_cnt3_fall: got %b want 0", clk_out); else passed++;
    step();
    step();
    step();
    total++; if (tick !== 1'b0 || clk_out !== 1'b0)
      $display("FAIL stop_cnt6: got tick=%b clk=%b want 0/0", tick, clk_out); else passed++;
    step();
    total++; if (tick !== 1'b0 || clk_out !== 1'b0)
      $display("FAIL stop_idle_entry: got tick=%b clk=%b want 0/0", tick, clk_out); else passed++;
    highs = 0;
    repeat (20) begin
      @(clk);
      #1;
      if (clk_out !== 1'b0 || tick !== 1'b0) highs++;
    end
    total++; if (highs !== 0) $display("FAIL stop_idle_quiet: got %0d active samples want 0", highs); else passed++;
    en = 1'b1;
    step();
    total++; if (tick !== 1'b1 || clk_out !== 1'b1)
      $display("FAIL stop_restart: got tick=%b clk=%b want 1/1", tick, clk_out); else passed++;
  endtask

  task automatic test_reset_mid();
    int hi, lo;
    bit ok, found;
    load(8'd5);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tick === 1'b1 && div_cur === 8'd5) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (!found) $display("FAIL rstmid_reach_n5: got timeout want tick with div=5"); else passed++;
    load(8'd9);
    @(negedge clk);
    #1;
    total++; if (clk_out !== 1'b1) $display("FAIL rstmid_pre_high: got %b want 1", clk_out); else passed++;
    #1;
    reset_n = 1'b0;
    en      = 1'b0;
    #1;
    total++; if (clk_out !== 1'b0 || tick !== 1'b0 || div_cur !== 8'd5)
      $display("FAIL rstmid_async: got clk=%b tick=%b div=%0d want 0/0/5", clk_out, tick, div_cur); else passed++;
    @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (clk_out !== 1'b0) $display("FAIL rstmid_held: got %b want 0", clk_out); else passed++;
    reset_n = 1'b1;
    step();
    total++; if (clk_out !== 1'b0) $display("FAIL rstmid_idle: got %b want 0", clk_out); else passed++;
    en = 1'b1;
    step();
    total++; if (tick !== 1'b1 || clk_out !== 1'b1 || div_cur !== 8'd5)
      $display("FAIL rstmid_restart: got tick=%b clk=%b div=%0d want 1/1/5", tick, clk_out, div_cur); else passed++;
    measure(hi, lo, ok);
    total++; if (!ok || hi !== 5 || lo !== 5)
      $display("FAIL rstmid_shape: got hi=%0d lo=%0d ok=%0d want hi=5 lo=5 halves", hi, lo, ok); else passed++;
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    reset_n  = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_in   = 8'd0;
    test_reset();
    test_default();
    test_load_mid();
    test_err();
    test_ratios();
    test_stop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
